// File: rtl/jtdd2_snd_mix.sv
// jtdd2_snd_mix: mixes YM2151 and OKI6295 audio with programmable 4.4 gains,
// saturates the sum and runs an optional one-pole low-pass on one shared multiplier.
module jtdd2_snd_mix #(
    parameter int unsigned LPF_SH       = 2,
    parameter logic [7:0]  GAIN_FM_RST  = 8'h10,
    parameter logic [7:0]  GAIN_PCM_RST = 8'h18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_in,
    input  logic signed [15:0] fm_snd,
    input  logic signed [13:0] pcm_snd,
    input  logic               gain_wr,
    input  logic               gain_sel,
    input  logic [7:0]         gain_din,
    input  logic               mute,
    input  logic               clr_flags,
    output logic signed [15:0] sound,
    output logic               sample_out,
    output logic               sat_flag,
    output logic               ovr_flag
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        MUL_FM  = 3'd2,
        MUL_PCM = 3'd3,
        SAT     = 3'd4,
        FILT    = 3'd5,
        OUT     = 3'd6
    } state_t;

    localparam logic signed [20:0] ACC_MAX  = 21'sd32767;
    localparam logic signed [20:0] ACC_MIN  = -21'sd32768;
    localparam logic signed [17:0] FILT_MAX = 18'sd32767;
    localparam logic signed [17:0] FILT_MIN = -18'sd32768;

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic [7:0]         gain_fm_q, gain_pcm_q;
    logic signed [15:0] fm_x_q, pcm_x_q;
    logic [7:0]         gfm_q, gpcm_q;
    logic               mute_q;
    logic signed [20:0] acc_q, acc_d;
    logic signed [15:0] x_q;
    logic signed [15:0] y_q;
    logic signed [15:0] ynext_q;
    logic signed [15:0] sound_q;
    logic               sample_out_q;
    logic               sat_q, ovr_q;
    logic               sat_set, ovr_set;

    // Shared multiplier: the sequencer steers FM or PCM operands onto it
    logic signed [15:0] mul_a;
    logic [7:0]         mul_g;
    logic signed [24:0] prod;
    logic signed [20:0] prod_sh;

    always_comb begin
        mul_a = fm_x_q;
        mul_g = gfm_q;
        if (state_q == MUL_PCM) begin
            mul_a = pcm_x_q;
            mul_g = gpcm_q;
        end
    end

    assign prod    = mul_a * $signed({1'b0, mul_g});
    assign prod_sh = prod[24:4];

    logic               sat_hi, sat_lo;
    logic signed [15:0] sat_val;

    assign sat_hi = (acc_q > ACC_MAX);
    assign sat_lo = (acc_q < ACC_MIN);

    always_comb begin
        sat_val = acc_q[15:0];
        if (sat_hi) begin
            sat_val = 16'sh7FFF;
        end else if (sat_lo) begin
            sat_val = 16'sh8000;
        end
    end

    // Low-pass at 18 bits so the difference term cannot wrap before the shift
    logic signed [17:0] x_ext, y_ext, diff, step, ysum;
    logic signed [15:0] filt_val;

    assign x_ext = $signed({{2{x_q[15]}}, x_q});
    assign y_ext = $signed({{2{y_q[15]}}, y_q});
    assign diff  = x_ext - y_ext;
    assign step  = diff >>> LPF_SH;
    assign ysum  = y_ext + step;

    always_comb begin
        filt_val = ysum[15:0];
        if (ysum > FILT_MAX) begin
            filt_val = 16'sh7FFF;
        end else if (ysum < FILT_MIN) begin
            filt_val = 16'sh8000;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        acc_d     = acc_q;
        sat_set   = 1'b0;
        ovr_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_in || pending_q) begin
                    state_d   = LATCH;
                    pending_d = 1'b0;
                end
            end
            LATCH:   state_d = MUL_FM;
            MUL_FM: begin
                acc_d   = prod_sh;
                state_d = MUL_PCM;
            end
            MUL_PCM: begin
                acc_d   = mute_q ? '0 : (acc_q + prod_sh);
                state_d = SAT;
            end
            SAT: begin
                sat_set = sat_hi | sat_lo;
                state_d = FILT;
            end
            FILT:    state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // One strobe may queue behind a busy pass; any further one is lost
        if ((state_q != IDLE) && sample_in) begin
            if (pending_q) begin
                ovr_set = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            gain_fm_q    <= GAIN_FM_RST;
            gain_pcm_q   <= GAIN_PCM_RST;
            fm_x_q       <= '0;
            pcm_x_q      <= '0;
            gfm_q        <= '0;
            gpcm_q       <= '0;
            mute_q       <= 1'b0;
            acc_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ynext_q      <= '0;
            sound_q      <= '0;
            sample_out_q <= 1'b0;
            sat_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            if (gain_wr) begin
                if (gain_sel) begin
                    gain_pcm_q <= gain_din;
                end else begin
                    gain_fm_q <= gain_din;
                end
            end
            if (state_q == LATCH) begin
                fm_x_q  <= fm_snd;
                pcm_x_q <= {pcm_snd, 2'b00};
                gfm_q   <= gain_fm_q;
                gpcm_q  <= gain_pcm_q;
                mute_q  <= mute;
            end
            if (state_q == SAT) begin
                x_q <= sat_val;
            end
            if (state_q == FILT) begin
                ynext_q <= filt_val;
            end
            if (state_q == OUT) begin
                sound_q <= ynext_q;
                y_q     <= ynext_q;
            end
            sample_out_q <= (state_q == OUT);
            sat_q        <= sat_set | (sat_q & ~clr_flags);
            ovr_q        <= ovr_set | (ovr_q & ~clr_flags);
        end
    end

    assign sound      = sound_q;
    assign sample_out = sample_out_q;
    assign sat_flag   = sat_q;
    assign ovr_flag   = ovr_q;

endmodule

// File: tb/tb_jtdd2_snd_mix.sv
// Self-checking bench for jtdd2_snd_mix: an unfiltered and a filtered instance
// share stimulus and are compared against an arithmetic model of the mix.
module tb_jtdd2_snd_mix;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_in;
    logic signed [15:0] fm_snd;
    logic signed [13:0] pcm_snd;
    logic               gain_wr;
    logic               gain_sel;
    logic [7:0]         gain_din;
    logic               mute;
    logic               clr_flags;

    logic signed [15:0] sound0, sound2;
    logic               sample_out0, sample_out2;
    logic               sat0, sat2, ovr0, ovr2;

    always #5 clk = ~clk;

    jtdd2_snd_mix #(.LPF_SH(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .fm_snd(fm_snd),
        .pcm_snd(pcm_snd), .gain_wr(gain_wr), .gain_sel(gain_sel),
        .gain_din(gain_din), .mute(mute), .clr_flags(clr_flags),
        .sound(sound0), .sample_out(sample_out0), .sat_flag(sat0), .ovr_flag(ovr0)
    );

    jtdd2_snd_mix #(.LPF_SH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .fm_snd(fm_snd),
        .pcm_snd(pcm_snd), .gain_wr(gain_wr), .gain_sel(gain_sel),
        .gain_din(gain_din), .mute(mute), .clr_flags(clr_flags),
        .sound(sound2), .sample_out(sample_out2), .sat_flag(sat2), .ovr_flag(ovr2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int gfm_m, gpcm_m;
    int y0_m, y2_m;
    int sat_m, ovr_m;
    int cur_fm, cur_pcm, cur_mute;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int v, input int sh);
        int d;
        d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        gfm_m  = 16;
        gpcm_m = 24;
        y0_m   = 0;
        y2_m   = 0;
        sat_m  = 0;
        ovr_m  = 0;
    endtask

    task automatic step_model();
        int acc;
        int x;
        acc = fdiv(cur_fm * gfm_m, 4) + fdiv(cur_pcm * 4 * gpcm_m, 4);
        if (cur_mute != 0) acc = 0;
        x = acc;
        if (acc > 32767) begin
            x = 32767;
            sat_m = 1;
        end else if (acc < -32768) begin
            x = -32768;
            sat_m = 1;
        end
        y0_m = x;
        y2_m = y2_m + fdiv(x - y2_m, 2);
    endtask

    task automatic set_inputs(input int fm, input int pcm, input int mu);
        cur_fm   = fm;
        cur_pcm  = pcm;
        cur_mute = mu;
        fm_snd   = 16'(fm);
        pcm_snd  = 14'(pcm);
        mute     = (mu != 0);
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_sat0"}, int'(sat0), sat_m);
        check_val({tag, "_sat2"}, int'(sat2), sat_m);
        check_val({tag, "_ovr0"}, int'(ovr0), ovr_m);
        check_val({tag, "_ovr2"}, int'(ovr2), ovr_m);
    endtask

    // Drives sample_in per mask bit, one bit per clock, and checks every output pulse
    task automatic run_pass(input logic [31:0] mask, input int ncyc,
                            output int np0, output int np2, output int first);
        np0 = 0;
        np2 = 0;
        first = -1;
        for (int c = 0; c < ncyc; c++) begin
            sample_in = mask[c];
            tick();
            sample_in = 1'b0;
            if (sample_out2) np2++;
            if (sample_out0) begin
                np0++;
                if (first < 0) first = c;
                step_model();
                check_val("sound_lpf0", int'(sound0), y0_m);
                check_val("sound_lpf2", int'(sound2), y2_m);
            end
        end
    endtask

    task automatic do_sample(input int fm, input int pcm, input int mu);
        int np0, np2, first;
        set_inputs(fm, pcm, mu);
        run_pass(32'h1, 10, np0, np2, first);
        check_val("pulses0", np0, 1);
        check_val("pulses2", np2, 1);
        check_val("latency", first, 6);
        check_flags("pass");
        $display("sample fm=%0d pcm=%0d mute=%0d -> sound0=%0d sound2=%0d sat=%0d ovr=%0d",
                 fm, pcm, mu, sound0, sound2, sat0, ovr0);
    endtask

    task automatic write_gain(input logic sel, input logic [7:0] val);
        gain_wr  = 1'b1;
        gain_sel = sel;
        gain_din = val;
        tick();
        gain_wr  = 1'b0;
        if (sel) gpcm_m = int'(val);
        else     gfm_m  = int'(val);
        $display("gain write sel=%0d val=0x%02h", sel, val);
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        sat_m = 0;
        ovr_m = 0;
        $display("flags cleared");
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_sound0"}, int'(sound0), 0);
        check_val({tag, "_sound2"}, int'(sound2), 0);
        check_val({tag, "_sout0"}, int'(sample_out0), 0);
        check_val({tag, "_sout2"}, int'(sample_out2), 0);
        check_flags(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        model_reset();
        check_reset_state("in_reset");
        rst_n = 1'b1;
        tick();
        check_reset_state("post_reset");
        $display("reset applied");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int np0, np2, first;
        int lpf_exp [4];
        lpf_exp = '{1024, 1792, 2368, 2800};

        rst_n     = 1'b0;
        sample_in = 1'b0;
        gain_wr   = 1'b0;
        gain_sel  = 1'b0;
        gain_din  = 8'h00;
        clr_flags = 1'b0;
        set_inputs(0, 0, 0);
        model_reset();

        // Reset defaults and gain registers
        apply_reset();
        do_sample(0, 100, 0);
        check_val("pcm_default_gain", int'(sound0), 600);
        write_gain(1'b0, 8'h20);
        do_sample(1000, 0, 0);
        check_val("fm_gain_x2", int'(sound0), 2000);

        // Unity mix
        write_gain(1'b0, 8'h10);
        write_gain(1'b1, 8'h10);
        do_sample(1000, 100, 0);
        check_val("unity_mix", int'(sound0), 1400);
        check_val("unity_sat", int'(sat0), 0);

        // Saturation and sticky flag behaviour
        do_sample(30000, 8000, 0);
        check_val("sat_pos", int'(sound0), 32767);
        check_val("sat_pos_flag", int'(sat0), 1);
        do_sample(0, 0, 0);
        check_val("sat_zero", int'(sound0), 0);
        check_val("sat_sticky", int'(sat0), 1);
        clear_flags();
        check_val("sat_cleared", int'(sat0), 0);
        do_sample(-30000, -8000, 0);
        check_val("sat_neg", int'(sound0), -32768);
        check_val("sat_neg_flag", int'(sat0), 1);

        // Low-pass step response on the filtered instance
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_sample(4096, 0, 0);
            check_val("lpf_step", int'(sound2), lpf_exp[k]);
        end

        // Overrun: two extra strobes while busy
        clear_flags();
        set_inputs(1234, -500, 0);
        run_pass(32'b1101, 24, np0, np2, first);
        ovr_m = 1;
        check_val("ovr2_pulses0", np0, 2);
        check_val("ovr2_pulses2", np2, 2);
        check_flags("ovr2");
        $display("overrun x2 -> pulses=%0d ovr=%0d", np0, ovr0);

        // One extra strobe landing in the OUT cycle queues a second pass
        clear_flags();
        set_inputs(-2222, 777, 0);
        run_pass(32'h41, 24, np0, np2, first);
        check_val("ovr1_pulses0", np0, 2);
        check_val("ovr1_pulses2", np2, 2);
        check_flags("ovr1");
        $display("overrun x1 -> pulses=%0d ovr=%0d", np0, ovr0);

        // Mute
        do_sample(5000, 0, 1);
        check_val("mute", int'(sound0), 0);

        // Reset in the middle of a pass (during MUL_PCM)
        set_inputs(9000, 1000, 0);
        np0 = 0;
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (sample_out0 || sample_out2) np0++;
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (sample_out0 || sample_out2) np0++;
        end
        check_val("midreset_pulses", np0, 0);
        check_reset_state("midreset");
        $display("mid-pass reset -> pulses=%0d sound0=%0d", np0, sound0);
        do_sample(1000, 100, 0);

        // Randomized passes
        for (int i = 0; i < 60; i++) begin
            int fmv, pcmv, muv;
            if ($urandom_range(0, 3) == 0) write_gain(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) clear_flags();
            fmv  = int'($urandom_range(0, 65535)) - 32768;
            pcmv = int'($urandom_range(0, 16383)) - 8192;
            muv  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            do_sample(fmv, pcmv, muv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
